// File: rtl/my_axi4_lite_pkg.sv
// my_axi4_lite_pkg: shared AXI4-Lite response type and register address decode
//   axi4_resp_t     AXI response encoding
//   reg_index       word index taken from an address
//   addr_in_range   index below the register count and no address bits set above it
package my_axi4_lite_pkg;
    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} axi4_resp_t;

    function automatic logic [31:0] reg_index(input logic [63:0] addr, input int lsb, input int idx_w);
        return 32'((addr >> lsb) & ((64'd1 << idx_w) - 64'd1));
    endfunction

    function automatic logic addr_in_range(input logic [63:0] addr, input int lsb, input int idx_w, input int num_regs);
        return ((addr >> (lsb + idx_w)) == 64'd0) && (reg_index(addr, lsb, idx_w) < 32'(num_regs));
    endfunction
endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite bundle
//   slv_port  slave view (valid/data in, ready/response out)
//   mst_port  master view
interface axi4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 4,
    parameter int DATA_BIT_WIDTH = 32
);
    logic                        awvalid, awready;
    logic [ADDR_BIT_WIDTH-1:0]   awaddr;
    logic                        wvalid, wready;
    logic [DATA_BIT_WIDTH-1:0]   wdata;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                        bvalid, bready;
    logic [1:0]                  bresp;
    logic                        arvalid, arready;
    logic [ADDR_BIT_WIDTH-1:0]   araddr;
    logic                        rvalid, rready;
    logic [DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;

    modport slv_port (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport mst_port (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/my_axi4_lite_wr_collector.sv
// my_axi4_lite_wr_collector: one-entry AW and W buffers, commit strobe and B channel
//   i_aw*/i_w*/i_bready, o_awready/o_wready/o_bvalid/o_bresp   AXI write channels
//   i_commit_resp   response for the buffered address, decided by the register file
//   o_commit        both buffers full; the register file writes o_addr/o_data/o_strb this cycle
module my_axi4_lite_wr_collector
    import my_axi4_lite_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_sync_rst,
    input  logic                i_awvalid,
    input  logic [ADDR_W-1:0]   i_awaddr,
    input  logic                i_wvalid,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_bready,
    input  axi4_resp_t          i_commit_resp,
    output logic                o_awready,
    output logic                o_wready,
    output logic                o_bvalid,
    output axi4_resp_t          o_bresp,
    output logic                o_commit,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [DATA_W-1:0]   o_data,
    output logic [DATA_W/8-1:0] o_strb
);
    logic                aw_full_q, aw_full_d, w_full_q, w_full_d, bvalid_q, bvalid_d, aw_hs, w_hs;
    axi4_resp_t          bresp_q, bresp_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W/8-1:0] strb_q, strb_d;

    assign o_awready = !aw_full_q && !bvalid_q;
    assign o_wready  = !w_full_q && !bvalid_q;
    assign o_commit  = aw_full_q && w_full_q;
    assign o_bvalid  = bvalid_q;
    assign o_bresp   = bresp_q;
    assign o_addr    = addr_q;
    assign o_data    = data_q;
    assign o_strb    = strb_q;

    always_comb begin
        aw_hs     = i_awvalid && o_awready;
        w_hs      = i_wvalid && o_wready;
        aw_full_d = o_commit ? 1'b0 : (aw_hs ? 1'b1 : aw_full_q);
        w_full_d  = o_commit ? 1'b0 : (w_hs ? 1'b1 : w_full_q);
        addr_d    = aw_hs ? i_awaddr : addr_q;
        data_d    = w_hs ? i_wdata : data_q;
        strb_d    = w_hs ? i_wstrb : strb_q;
        bvalid_d  = o_commit ? 1'b1 : (bvalid_q && !i_bready);
        bresp_d   = o_commit ? i_commit_resp : bresp_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end
endmodule

// File: rtl/my_axi4_lite_slv_reg_file.sv
// my_axi4_lite_slv_reg_file: AXI4-Lite slave register file with RW and RO registers
//   i_clk, i_sync_rst   clock, synchronous active-high reset
//   if_s_axi4_lite      AXI4-Lite slave port
//   o_regs              RW register contents, RO slices read as 0
//   i_ro_vals           values returned for RO registers
//   o_wr_pulse          one-cycle pulse per register on an OKAY write
module my_axi4_lite_slv_reg_file
    import my_axi4_lite_pkg::*;
#(
    parameter int                                  NUM_REGS       = 4,
    parameter int                                  ADDR_BIT_WIDTH = 4,
    parameter int                                  DATA_BIT_WIDTH = 32,
    parameter logic [NUM_REGS-1:0]                 RO_MASK        = '0,
    parameter logic [NUM_REGS*DATA_BIT_WIDTH-1:0]  RST_VALS       = '0
) (
    input  logic                               i_clk,
    input  logic                               i_sync_rst,
    axi4_lite_if.slv_port                      if_s_axi4_lite,
    output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] o_regs,
    input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0] i_ro_vals,
    output logic [NUM_REGS-1:0]                o_wr_pulse
);
    localparam int DW       = DATA_BIT_WIDTH;
    localparam int ADDR_LSB = $clog2(DW / 8);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    if (if_s_axi4_lite.ADDR_BIT_WIDTH != ADDR_BIT_WIDTH || if_s_axi4_lite.DATA_BIT_WIDTH != DATA_BIT_WIDTH) begin : g_width_err
        $error("axi4_lite_if widths differ from register file parameters");
    end

    logic                      commit, wr_in, wr_ok, rd_in, ar_hs;
    logic [ADDR_BIT_WIDTH-1:0] wr_addr, ar_addr_q, ar_addr_d;
    logic [DW-1:0]             wr_data, rd_val, rdata_q, rdata_d;
    logic [DW/8-1:0]           wr_strb;
    logic [NUM_REGS-1:0]       wr_sel, wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS*DW-1:0]    regs_q, regs_d, rst_rw;
    logic                      ar_pending_q, ar_pending_d, rvalid_q, rvalid_d;
    axi4_resp_t                wr_resp, bresp, rresp_q, rresp_d;

    my_axi4_lite_wr_collector #(.ADDR_W(ADDR_BIT_WIDTH), .DATA_W(DW)) u_wr (
        .i_clk         (i_clk),
        .i_sync_rst    (i_sync_rst),
        .i_awvalid     (if_s_axi4_lite.awvalid),
        .i_awaddr      (if_s_axi4_lite.awaddr),
        .i_wvalid      (if_s_axi4_lite.wvalid),
        .i_wdata       (if_s_axi4_lite.wdata),
        .i_wstrb       (if_s_axi4_lite.wstrb),
        .i_bready      (if_s_axi4_lite.bready),
        .i_commit_resp (wr_resp),
        .o_awready     (if_s_axi4_lite.awready),
        .o_wready      (if_s_axi4_lite.wready),
        .o_bvalid      (if_s_axi4_lite.bvalid),
        .o_bresp       (bresp),
        .o_commit      (commit),
        .o_addr        (wr_addr),
        .o_data        (wr_data),
        .o_strb        (wr_strb)
    );

    assign if_s_axi4_lite.bresp   = bresp;
    assign if_s_axi4_lite.arready = !rvalid_q && !ar_pending_q;
    assign if_s_axi4_lite.rvalid  = rvalid_q;
    assign if_s_axi4_lite.rdata   = rdata_q;
    assign if_s_axi4_lite.rresp   = rresp_q;
    assign o_regs     = regs_q;
    assign o_wr_pulse = wr_pulse_q;

    always_comb begin
        rst_rw = RST_VALS;
        wr_in  = addr_in_range(64'(wr_addr), ADDR_LSB, IDX_W, NUM_REGS);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i]) rst_rw[i*DW +: DW] = '0;
            wr_sel[i] = wr_in && (reg_index(64'(wr_addr), ADDR_LSB, IDX_W) == 32'(i));
        end
        wr_ok      = wr_in && ((wr_sel & RO_MASK) == '0);
        wr_resp    = wr_ok ? OKAY : SLVERR;
        wr_pulse_d = (commit && wr_ok) ? wr_sel : '0;
        regs_d     = regs_q;
        for (int i = 0; i < NUM_REGS; i++)
            for (int b = 0; b < DW / 8; b++)
                if (wr_pulse_d[i] && wr_strb[b]) regs_d[i*DW + b*8 +: 8] = wr_data[b*8 +: 8];
    end

    // A read pending at a commit edge samples regs_q, so it sees the pre-write value.
    always_comb begin
        ar_hs  = if_s_axi4_lite.arvalid && if_s_axi4_lite.arready;
        rd_in  = addr_in_range(64'(ar_addr_q), ADDR_LSB, IDX_W, NUM_REGS);
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_in && reg_index(64'(ar_addr_q), ADDR_LSB, IDX_W) == 32'(i))
                rd_val = RO_MASK[i] ? i_ro_vals[i*DW +: DW] : regs_q[i*DW +: DW];
        ar_pending_d = ar_hs;
        ar_addr_d    = ar_hs ? if_s_axi4_lite.araddr : ar_addr_q;
        rvalid_d     = ar_pending_q ? 1'b1 : (rvalid_q && !if_s_axi4_lite.rready);
        rdata_d      = ar_pending_q ? rd_val : rdata_q;
        rresp_d      = ar_pending_q ? (rd_in ? OKAY : SLVERR) : rresp_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            regs_q       <= rst_rw;
            wr_pulse_q   <= '0;
            ar_pending_q <= 1'b0;
            ar_addr_q    <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= OKAY;
        end else begin
            regs_q       <= regs_d;
            wr_pulse_q   <= wr_pulse_d;
            ar_pending_q <= ar_pending_d;
            ar_addr_q    <= ar_addr_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
        end
    end
endmodule
